// File: rtl/rwb_pkg.sv
// Shared types and constants for the register write-back block.
// Contents:
//   rwb_state_t        - FSM state (IDLE / LOAD_WAIT)
//   REG_ACC/REG_STATUS - architectural register indices
//   LOAD_TIMEOUT_DATA  - data written when a load is force-completed
//   commit_t           - data/flag pair for one write-port commit
package rwb_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } rwb_state_t;

  localparam int          REG_ACC           = 0;
  localparam int          REG_STATUS        = 15;
  localparam logic [7:0]  LOAD_TIMEOUT_DATA = 8'hFF;

  typedef struct packed {
    logic [7:0] data;
    logic       flag;
  } commit_t;

endpackage

// File: rtl/reg_writeback_mem_wait_timer.sv
// mem_wait_timer: bounded wait counter for outstanding loads.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - begin counting (count restarts at 0)
//   clear       - stop counting
//   expired     - high during the TIMEOUT-th counted cycle after start
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          run;

  // Cycle k after start sees cnt == k-1, so expiry lands on cycle TIMEOUT.
  assign expired = run && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= 1'b1;
    end else if (clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-side driver for reg_file.
// Accepts ALU results and loads from execute (valid/ready), issues
// data-memory reads for loads with a bounded wait, and drives one
// registered reg_file write per committed op.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   ex_valid/ex_ready              - execute handshake
//   ex_dest/ex_data/ex_flag        - ALU result and destination
//   ex_is_load/ex_mem_addr         - load op and its address
//   mem_req/mem_addr               - data-memory read request
//   mem_rvalid/mem_rdata           - data-memory read response
//   wr_en/wr_addr/dat_in/flag      - reg_file write port
//   mem_err                        - sticky load-timeout indicator
// Optional build macro RWB_FORWARD_EN adds fwd_valid/fwd_addr/fwd_data,
// a copy of the write being committed, for execute-side bypass.
module reg_writeback
  import rwb_pkg::*;
#(
  parameter int PW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [PW-1:0] ex_dest,
  input  logic [7:0]    ex_data,
  input  logic          ex_flag,
  input  logic          ex_is_load,
  input  logic [7:0]    ex_mem_addr,
  output logic          mem_req,
  output logic [7:0]    mem_addr,
  input  logic          mem_rvalid,
  input  logic [7:0]    mem_rdata,
  output logic          wr_en,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    dat_in,
  output logic          flag,
  output logic          mem_err
`ifdef RWB_FORWARD_EN
  ,
  output logic          fwd_valid,
  output logic [PW-1:0] fwd_addr,
  output logic [7:0]    fwd_data
`endif
);

  // Highest register is the status register; writes to it are dropped.
  localparam logic [PW-1:0] STATUS_IDX = '1;

  rwb_state_t    state, nxt_state;
  logic [PW-1:0] ld_dest_q;
  logic [7:0]    mem_addr_q;
  logic          flag_q;
  logic          mem_err_q;

  logic          accept;
  logic          tmr_start, tmr_clear, tmr_expired;
  logic          ld_done, ld_tmo;

  logic          c_vld;
  logic [PW-1:0] c_addr;
  commit_t       c_pay;

  assign accept = ex_valid && ex_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  // rvalid wins over an expiry landing in the same cycle.
  assign ld_done   = (state == LOAD_WAIT) && (mem_rvalid || tmr_expired);
  assign ld_tmo    = (state == LOAD_WAIT) && !mem_rvalid && tmr_expired;
  assign tmr_start = accept && ex_is_load;
  assign tmr_clear = ld_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:      if (accept && ex_is_load) nxt_state = LOAD_WAIT;
      LOAD_WAIT: if (ld_done)              nxt_state = IDLE;
      default:   nxt_state = IDLE;
    endcase
  end

  // Output / commit decode
  always_comb begin
    ex_ready   = 1'b0;
    mem_req    = 1'b0;
    c_vld      = 1'b0;
    c_addr     = ex_dest;
    c_pay.data = ex_data;
    c_pay.flag = ex_flag;
    case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (accept && !ex_is_load) c_vld = (ex_dest != STATUS_IDX);
      end
      LOAD_WAIT: begin
        mem_req    = 1'b1;
        c_addr     = ld_dest_q;
        c_pay.data = mem_rvalid ? mem_rdata : LOAD_TIMEOUT_DATA;
        c_pay.flag = flag_q;
        if (ld_done) c_vld = (ld_dest_q != STATUS_IDX);
      end
      default: ;
    endcase
  end

  // Write port and load context. wr_addr/dat_in/flag only move on a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      dat_in     <= '0;
      flag       <= 1'b0;
      flag_q     <= 1'b0;
      ld_dest_q  <= '0;
      mem_addr_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wr_en <= c_vld;
      if (c_vld) begin
        wr_addr <= c_addr;
        dat_in  <= c_pay.data;
        flag    <= c_pay.flag;
      end
      if (accept && !ex_is_load) flag_q <= ex_flag;
      if (accept && ex_is_load) begin
        ld_dest_q  <= ex_dest;
        mem_addr_q <= ex_mem_addr;
      end
      if (ld_tmo) mem_err_q <= 1'b1;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_err  = mem_err_q;

`ifdef RWB_FORWARD_EN
  assign fwd_valid = wr_en;
  assign fwd_addr  = wr_addr;
  assign fwd_data  = dat_in;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  localparam int PW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_ready;
  logic [PW-1:0] ex_dest;
  logic [7:0]    ex_data;
  logic          ex_flag, ex_is_load;
  logic [7:0]    ex_mem_addr;
  logic          mem_req;
  logic [7:0]    mem_addr;
  logic          mem_rvalid;
  logic [7:0]    mem_rdata;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [7:0]    dat_in;
  logic          flag, mem_err;
`ifdef RWB_FORWARD_EN
  logic          fwd_valid;
  logic [PW-1:0] fwd_addr;
  logic [7:0]    fwd_data;
`endif

  reg_writeback #(.PW(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_dest(ex_dest), .ex_data(ex_data),
    .ex_flag(ex_flag), .ex_is_load(ex_is_load), .ex_mem_addr(ex_mem_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in), .flag(flag), .mem_err(mem_err)
`ifdef RWB_FORWARD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] a;
    logic [7:0]    d;
    logic          f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: architectural flag and sticky error.
  logic flag_m;
  logic err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the oldest expected commit.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual addr=%0d data=%0h required no write", wr_addr, dat_in);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wr_addr !== e.a || dat_in !== e.d || flag !== e.f) begin
          errors++;
          $display("FAIL wr_commit actual a=%0d d=%0h f=%0b required a=%0d d=%0h f=%0b",
                   wr_addr, dat_in, flag, e.a, e.d, e.f);
        end
      end
    end
`ifdef RWB_FORWARD_EN
    if (fwd_valid !== wr_en || (wr_en && (fwd_addr !== wr_addr || fwd_data !== dat_in))) begin
      checks++; errors++;
      $display("FAIL fwd_path actual v=%0b a=%0d d=%0h", fwd_valid, fwd_addr, fwd_data);
    end
`endif
  end

  task automatic push(input logic [PW-1:0] a, input logic [7:0] d, input logic f);
    exp_t e;
    if (a != PW'(15)) begin
      e.a = a; e.d = d; e.f = f;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex_valid = 1'b0; ex_is_load = 1'b0; mem_rvalid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    flag_m = 1'b0; err_m = 1'b0;
  endtask

  // Present one ALU op for exactly one edge; stray rvalid is noise in IDLE.
  task automatic issue_alu(input logic [PW-1:0] d, input logic [7:0] v, input logic f);
    @(negedge clk);
    chk("alu_ready", ex_ready, 1);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_dest = d; ex_data = v; ex_flag = f;
    mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
    push(d, v, f);
    flag_m = f;
  endtask

  // Load whose response comes in wait cycle 'delay' (1 = first wait cycle);
  // delay > TO means no response.
  task automatic issue_load(input logic [PW-1:0] d, input logic [7:0] a,
                            input int delay, input logic [7:0] v);
    @(negedge clk);
    chk("ld_accept_ready", ex_ready, 1);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = d; ex_mem_addr = a;
    ex_data = 8'($urandom); ex_flag = ~flag_m; mem_rvalid = 1'b0;
    push(d, (delay <= TO) ? v : 8'hFF, flag_m);
    if (delay > TO) err_m = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_mem_addr = 8'($urandom);
    for (int k = 1; k <= TO; k++) begin
      chk("ld_ready_low", ex_ready, 0);
      chk("ld_req", mem_req, 1);
      chk("ld_addr", mem_addr, a);
      if (k == delay) begin
        mem_rvalid = 1'b1; mem_rdata = v;
        @(negedge clk);
        mem_rvalid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk("ld_done_ready", ex_ready, 1);
    chk("ld_done_req", mem_req, 0);
    chk("ld_mem_err", mem_err, err_m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_dest = '0; ex_data = '0;
    ex_flag = 1'b0; ex_mem_addr = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    flag_m = 1'b0; err_m = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", ex_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_dat_in", dat_in, 0);
    chk("rst_flag", flag, 0);
    chk("rst_mem_err", mem_err, 0);

    // 1: single ALU op
    issue_alu(4'd3, 8'h5A, 1'b1);
    idle(2);
    // 2: load with response in third wait cycle, flag unchanged
    issue_load(4'd6, 8'h20, 3, 8'hC3);
    idle(1);
    // 3: load timeout, sticky error
    issue_load(4'd2, 8'h44, TO + 3, 8'h00);
    idle(1);
    issue_alu(4'd1, 8'h11, 1'b0);
    idle(2);
    chk("err_sticky", mem_err, 1);
    // 4: status-register destination is consumed silently
    issue_alu(4'd15, 8'h77, 1'b0);
    idle(2);
    // 6: back-to-back ALU ops
    issue_alu(4'd4, 8'hA1, 1'b0);
    issue_alu(4'd5, 8'hB2, 1'b1);
    issue_alu(4'd6, 8'hC3, 1'b0);
    issue_alu(4'd7, 8'hD4, 1'b1);
    idle(2);
    chk("b2b_drained", sb.size(), 0);
    // 5: reset in the middle of a load, late rvalid ignored
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 4'd9; ex_mem_addr = 8'h30;
    repeat (3) @(negedge clk) ex_valid = 1'b0;
    chk("mid_req_before", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; flag_m = 1'b0; err_m = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 8'hEE;
    chk("mid_ready", ex_ready, 1);
    chk("mid_req", mem_req, 0);
    chk("mid_err_clear", mem_err, 0);
    idle(3);
    chk("mid_ready_late", ex_ready, 1);

    // random mix
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0)
        issue_load(PW'($urandom_range(0, 15)), 8'($urandom),
                   int'($urandom_range(1, TO + 3)), 8'($urandom));
      else
        issue_alu(PW'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(3);
    chk("sb_empty", sb.size(), 0);
    chk("final_err", mem_err, err_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
